// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter, return-address stack and fetch sequencer
module pc_fetch_unit #(
   parameter logic [9:0] RESET_ADDR = 10'd0,
   parameter int         RAS_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic [9:0]  instr,
   input  logic [9:0]  jmp_addr,
   input  logic        eq_flag,
   output logic [9:0]  instr_rd_addr,
   output logic        halted,
   output logic        ras_fault,
   output logic [15:0] retired_cnt
);

   // Stack index width; the occupancy count needs one extra bit to reach RAS_DEPTH.
   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam logic [PTR_W:0] DEPTH_V = (PTR_W+1)'(RAS_DEPTH);
   localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   localparam logic [3:0] OP_J    = 4'b1100;
   localparam logic [3:0] OP_JE   = 4'b1101;
   localparam logic [3:0] OP_JAL  = 4'b1110;
   localparam logic [3:0] OP_HALT = 4'b1111;
   localparam logic [3:0] OP_RET  = 4'b0111;

   // Architectural state
   logic [9:0]     r_pc;
   logic [0:0]     r_state;
   logic           r_ras_fault;
   logic [15:0]    r_retired;
   logic [PTR_W:0] r_ras_cnt;
   logic [9:0]     r_ras [0:RAS_DEPTH-1];

   // Decode and next-state helpers
   logic [3:0]       w_opcode;
   logic             w_is_jal;
   logic             w_is_ret;
   logic             w_is_halt;
   logic             w_ras_full;
   logic             w_ras_empty;
   logic             w_overflow;
   logic             w_underflow;
   logic             w_fault;
   logic             w_active;
   logic             w_commit;
   logic [9:0]       w_pc_seq;
   logic [9:0]       w_pc_tgt;
   logic [9:0]       w_pc_next;
   logic [9:0]       w_ras_top;
   logic [PTR_W:0]   w_cnt_m1;
   logic [PTR_W-1:0] w_top_idx;
   logic [PTR_W-1:0] w_push_idx;

   assign w_opcode    = instr[9:6];
   assign w_is_jal    = (w_opcode == OP_JAL);
   assign w_is_ret    = (w_opcode == OP_RET);
   assign w_is_halt   = (w_opcode == OP_HALT);

   assign w_ras_full  = (r_ras_cnt == DEPTH_V);
   assign w_ras_empty = (r_ras_cnt == '0);
   assign w_overflow  = w_is_jal & w_ras_full;
   assign w_underflow = w_is_ret & w_ras_empty;
   assign w_fault     = w_overflow | w_underflow;

   // A cycle only does work when running and not stalled; a faulting
   // instruction is squashed entirely so PC, stack and counter keep their values.
   assign w_active    = (r_state == ST_RUN) & ~stall;
   assign w_commit    = w_active & ~w_fault;

   assign w_pc_seq    = r_pc + 10'd1;
   assign w_pc_tgt    = r_pc + jmp_addr;

   assign w_cnt_m1    = r_ras_cnt - CNT_ONE;
   assign w_top_idx   = w_cnt_m1[PTR_W-1:0];
   assign w_push_idx  = r_ras_cnt[PTR_W-1:0];
   assign w_ras_top   = r_ras[w_top_idx];

   // Select the next PC from the opcode of the instruction currently addressed
   always_comb begin
      w_pc_next = w_pc_seq;
      case (w_opcode)
         OP_J:    w_pc_next = w_pc_tgt;
         OP_JE:   w_pc_next = eq_flag ? w_pc_tgt : w_pc_seq;
         OP_JAL:  w_pc_next = w_pc_tgt;
         OP_RET:  w_pc_next = w_ras_top;
         OP_HALT: w_pc_next = r_pc;
         default: w_pc_next = w_pc_seq;
      endcase
   end

   // PC and RUN/HALT state; halt and faults freeze the PC until reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc        <= RESET_ADDR;
         r_state     <= ST_RUN;
         r_ras_fault <= 1'b0;
      end else if (w_active) begin
         if (w_fault) begin
            r_state     <= ST_HALT;
            r_ras_fault <= 1'b1;
         end else if (w_is_halt) begin
            r_state     <= ST_HALT;
         end else begin
            r_pc        <= w_pc_next;
         end
      end
   end

   // Return-address stack: jal pushes the fall-through address, ret pops
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ras_cnt <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            r_ras[i] <= 10'd0;
         end
      end else if (w_commit) begin
         if (w_is_jal) begin
            r_ras[w_push_idx] <= w_pc_seq;
            r_ras_cnt         <= r_ras_cnt + CNT_ONE;
         end else if (w_is_ret) begin
            r_ras_cnt         <= w_cnt_m1;
         end
      end
   end

   // Retired-instruction counter; the halt instruction itself is counted once
   always_ff @(posedge clk) begin
      if (rst) begin
         r_retired <= 16'd0;
      end else if (w_commit) begin
         r_retired <= r_retired + 16'd1;
      end
   end

   assign instr_rd_addr = r_pc;
   assign halted        = (r_state == ST_HALT);
   assign ras_fault     = r_ras_fault;
   assign retired_cnt   = r_retired;

endmodule
